// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    BR_FLUSH = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  // IDEX_MemRead encoding that marks "not a load"
  localparam logic [2:0] NO_LOAD    = 3'b101;
  // Consecutive memory-wait cycles that trip the watchdog
  localparam logic [7:0] WAIT_LIMIT = 8'd255;

  // Load-use: a real load in ID/EX writing a non-x0 register read in IF/ID
  function automatic logic is_load_use(input logic [2:0] memread,
                                       input logic [4:0] rd,
                                       input logic [4:0] rs1,
                                       input logic [4:0] rs2);
    return (memread != NO_LOAD) && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Stall / flush event counters (built only with HAZARD_PERF_CNT_EN).
// Both counters wrap at 2^32 and clear on synchronous reset.
module hazard_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Next-state: bump each counter on its event, natural wrap
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall_i};
    flush_cnt_d = flush_cnt_q + {31'd0, flush_i};
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory wait
// with a sticky watchdog. Outputs are Mealy (state + current inputs).
// Optional: define HAZARD_PERF_CNT_EN for StallCount/FlushCount outputs.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  IFID_rs1,
  input  logic [4:0]  IFID_rs2,
  input  logic [4:0]  IDEX_rd,
  input  logic [2:0]  IDEX_MemRead,
  input  logic        EX_BranchTaken,
  input  logic        MEM_Busy,
  output logic        HazardSel,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IFIDFlush,
  output logic        PipeHold,
  output logic        Timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
`endif
);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
  logic        load_use;
  logic        lu_mask;

  assign load_use = is_load_use(IDEX_MemRead, IDEX_rd, IFID_rs1, IFID_rs2);
  // The cycle after a stall or flush the ID/EX contents are a bubble or
  // stale, so a load-use match there must not stall a second time.
  assign lu_mask  = (state_q == LU_STALL) || (state_q == BR_FLUSH);

  // Event resolution: every state applies the same priority chain
  // (busy > branch > load-use); only the load-use term is state-dependent.
  // MEM_WAIT with busy low therefore behaves exactly like RUN.
  always_comb begin
    state_d   = RUN;
    HazardSel = 1'b0;
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDFlush = 1'b0;
    PipeHold  = 1'b0;
    if (MEM_Busy) begin
      PipeHold  = 1'b1;
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      state_d   = MEM_WAIT;
    end else if (EX_BranchTaken) begin
      IFIDFlush = 1'b1;
      HazardSel = 1'b1;
      state_d   = BR_FLUSH;
    end else if (load_use && !lu_mask) begin
      HazardSel = 1'b1;
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      state_d   = LU_STALL;
    end
    // Reset drives a safe flushed/bubbled pipeline regardless of state
    if (reset) begin
      HazardSel = 1'b1;
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IFIDFlush = 1'b1;
      PipeHold  = 1'b0;
      state_d   = RUN;
    end
  end

  // Watchdog: wait_cnt_q equals the number of consecutive MEM_WAIT cycles
  // including the current one; Timeout rises together with the count hitting
  // the limit and then sticks.
  always_comb begin
    wait_cnt_d = 8'd0;
    if (state_d == MEM_WAIT)
      wait_cnt_d = (wait_cnt_q == WAIT_LIMIT) ? WAIT_LIMIT : wait_cnt_q + 8'd1;
    timeout_d = timeout_q | (wait_cnt_d == WAIT_LIMIT);
  end

  // State, wait counter and sticky timeout registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign Timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  // Reset cycles drive PCWrite=0 / IFIDFlush=1 but are not counted
  hazard_perf_cnt u_perf (
    .clk         (clk),
    .reset       (reset),
    .stall_i     (!PCWrite && !reset),
    .flush_i     (IFIDFlush && !reset),
    .stall_cnt_o (StallCount),
    .flush_cnt_o (FlushCount)
  );
`else
  // No performance counters in this build
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl plus multi-cycle sequences
// (watchdog timeout, reset mid-wait, optional perf counters).
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  IFID_rs1, IFID_rs2, IDEX_rd;
  logic [2:0]  IDEX_MemRead;
  logic        EX_BranchTaken, MEM_Busy;
  logic        HazardSel, PCWrite, IFIDWrite, IFIDFlush, PipeHold, Timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCount, FlushCount;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .IFID_rs1       (IFID_rs1),
    .IFID_rs2       (IFID_rs2),
    .IDEX_rd        (IDEX_rd),
    .IDEX_MemRead   (IDEX_MemRead),
    .EX_BranchTaken (EX_BranchTaken),
    .MEM_Busy       (MEM_Busy),
    .HazardSel      (HazardSel),
    .PCWrite        (PCWrite),
    .IFIDWrite      (IFIDWrite),
    .IFIDFlush      (IFIDFlush),
    .PipeHold       (PipeHold),
    .Timeout        (Timeout)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCount     (StallCount),
    .FlushCount     (FlushCount)
`endif
  );

  // One cycle of stimulus plus expected outputs
  // exp = {HazardSel, PCWrite, IFIDWrite, IFIDFlush, PipeHold, Timeout}
  typedef struct {
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic [2:0] mr;
    logic       br, busy;
    logic [5:0] exp;
  } vec_t;

  localparam logic [5:0] E_RST  = 6'b100100;
  localparam logic [5:0] E_DEF  = 6'b011000;
  localparam logic [5:0] E_LU   = 6'b100000;
  localparam logic [5:0] E_BR   = 6'b111100;
  localparam logic [5:0] E_HOLD = 6'b000010;

  vec_t tbl[23];

  function automatic vec_t mk(logic rst, logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, logic [2:0] mr, logic br,
                              logic busy, logic [5:0] exp);
    vec_t v;
    v.rst = rst; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.mr = mr;
    v.br = br; v.busy = busy; v.exp = exp;
    return v;
  endfunction

  task automatic drive(logic rst, logic [4:0] rs1, logic [4:0] rs2,
                       logic [4:0] rd, logic [2:0] mr, logic br, logic busy);
    reset = rst; IFID_rs1 = rs1; IFID_rs2 = rs2; IDEX_rd = rd;
    IDEX_MemRead = mr; EX_BranchTaken = br; MEM_Busy = busy;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {HazardSel, PCWrite, IFIDWrite, IFIDFlush, PipeHold, Timeout};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Cycle sequence; state carries from row to row.
    tbl[0]  = mk(1, 1, 2, 3, 3'b010, 0, 0, E_RST);   // reset values
    tbl[1]  = mk(0, 1, 2, 3, 3'b010, 0, 0, E_DEF);   // no match
    tbl[2]  = mk(0, 1, 5, 5, 3'b010, 0, 0, E_LU);    // load-use via rs2
    tbl[3]  = mk(0, 1, 5, 5, 3'b010, 0, 0, E_DEF);   // LU_STALL masks
    tbl[4]  = mk(0, 0, 0, 0, 3'b010, 0, 0, E_DEF);   // rd = x0
    tbl[5]  = mk(0, 1, 5, 5, 3'b101, 0, 0, E_DEF);   // not a load
    tbl[6]  = mk(0, 7, 2, 7, 3'b000, 0, 0, E_LU);    // load-use via rs1
    tbl[7]  = mk(0, 7, 2, 7, 3'b000, 1, 0, E_BR);    // branch in LU_STALL
    tbl[8]  = mk(0, 7, 2, 7, 3'b000, 0, 0, E_DEF);   // BR_FLUSH masks
    tbl[9]  = mk(0, 1, 5, 5, 3'b010, 1, 0, E_BR);    // branch beats load-use
    tbl[10] = mk(0, 1, 5, 5, 3'b010, 0, 0, E_DEF);   // no stall after
    tbl[11] = mk(0, 1, 5, 5, 3'b010, 1, 1, E_HOLD);  // busy beats all
    tbl[12] = mk(0, 1, 2, 3, 3'b010, 0, 1, E_HOLD);  // wait 2
    tbl[13] = mk(0, 1, 2, 3, 3'b010, 0, 1, E_HOLD);  // wait 3
    tbl[14] = mk(0, 1, 2, 3, 3'b010, 0, 0, E_DEF);   // 4th cycle defaults
    tbl[15] = mk(0, 1, 2, 3, 3'b010, 0, 1, E_HOLD);  // -> MEM_WAIT
    tbl[16] = mk(0, 4, 2, 4, 3'b011, 0, 0, E_LU);    // MEM_WAIT acts as RUN
    tbl[17] = mk(0, 1, 2, 3, 3'b010, 0, 1, E_HOLD);  // busy in LU_STALL
    tbl[18] = mk(0, 1, 2, 3, 3'b010, 1, 0, E_BR);    // MEM_WAIT branch
    tbl[19] = mk(0, 1, 2, 3, 3'b010, 0, 1, E_HOLD);  // busy in BR_FLUSH
    tbl[20] = mk(1, 1, 2, 3, 3'b010, 0, 1, E_RST);   // reset mid-wait
    tbl[21] = mk(0, 6, 2, 6, 3'b010, 0, 0, E_LU);    // back in RUN
    tbl[22] = mk(0, 1, 2, 3, 3'b010, 0, 0, E_DEF);

    drive(1, 0, 0, 0, 3'b101, 0, 0);
    tick();
    tick();

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].rst, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].mr,
            tbl[i].br, tbl[i].busy);
      #2;
      chk($sformatf("row%0d", i), {26'd0, outs()}, {26'd0, tbl[i].exp});
      tick();
    end

    // Watchdog: 300 busy cycles, Timeout visible from busy cycle 256
    for (int k = 1; k <= 300; k++) begin
      drive(0, 1, 2, 3, 3'b010, 0, 1);
      #2;
      chk($sformatf("wait%0d_hold", k), {31'd0, PipeHold}, 32'd1);
      chk($sformatf("wait%0d_tmo", k), {31'd0, Timeout}, (k >= 256) ? 32'd1 : 32'd0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 2, 3, 3'b010, 0, 0);
      #2;
      chk($sformatf("post_wait%0d", k), {26'd0, outs()}, {26'd0, E_DEF | 6'b000001});
      tick();
    end

    // Reset with Timeout set and in MEM_WAIT
    drive(0, 1, 2, 3, 3'b010, 0, 1);
    tick();
    drive(1, 1, 2, 3, 3'b010, 0, 1);
    #2;
    chk("rst_in_wait", {27'd0, outs() >> 1}, {27'd0, E_RST >> 1});
    tick();
    drive(0, 1, 2, 3, 3'b010, 0, 0);
    #2;
    chk("after_rst", {26'd0, outs()}, {26'd0, E_DEF});
    tick();

`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cnt_rst", StallCount, 32'd0);
    chk("flush_cnt_rst", FlushCount, 32'd0);
    drive(0, 1, 5, 5, 3'b010, 0, 0); tick();   // stall 1
    drive(0, 1, 2, 3, 3'b010, 0, 0); tick();
    drive(0, 8, 2, 8, 3'b010, 0, 0); tick();   // stall 2
    drive(0, 1, 2, 3, 3'b010, 0, 0); tick();
    drive(0, 1, 2, 3, 3'b010, 1, 0); tick();   // flush 1
    drive(0, 1, 2, 3, 3'b010, 0, 0); tick();
    chk("stall_cnt", StallCount, 32'd2);
    chk("flush_cnt", FlushCount, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high.
REQ-003 SHALL have port IFID_rs1, input, 5, rs1 field of the instruction in IF/ID.
REQ-004 SHALL have port IFID_rs2, input, 5, rs2 field of the instruction in IF/ID.
REQ-005 SHALL have port IDEX_rd, input, 5, destination register in ID/EX.
REQ-006 SHALL have port IDEX_MemRead, input, 3, ID/EX load control; 3'b101 = no load.
REQ-007 SHALL have port EX_BranchTaken, input, 1, taken branch/jump resolved in EX this cycle.
REQ-008 SHALL have port MEM_Busy, input, 1, data memory not ready this cycle.
REQ-009 SHALL have port HazardSel, output, 1, select line for the control-bubble mux (1 = bubble into ID/EX).
REQ-010 SHALL have ports PCWrite and IFIDWrite, output, 1 each, enables for PC and IF/ID.
REQ-011 SHALL have ports IFIDFlush and PipeHold, output, 1 each; PipeHold freezes ID/EX, EX/MEM and MEM/WB.
REQ-012 SHALL have port Timeout, output, 1, sticky memory-wait watchdog flag.

Function
REQ-013 SHALL implement FSM states RUN, LU_STALL, BR_FLUSH, MEM_WAIT; outputs are Mealy (state plus current inputs), with no added latency.
REQ-014 SHALL define load-use as: IDEX_MemRead != 3'b101, IDEX_rd != 0, and IDEX_rd equals IFID_rs1 or IFID_rs2.
REQ-015 SHALL produce default outputs (RUN, no event) of HazardSel=0, PCWrite=1, IFIDWrite=1, IFIDFlush=0, PipeHold=0.
REQ-016 SHALL use event priority MEM_Busy > EX_BranchTaken > load-use when events are simultaneous.
REQ-017 RUN with MEM_Busy SHALL give PipeHold=1, PCWrite=0, IFIDWrite=0, HazardSel=0, next state MEM_WAIT.
REQ-018 RUN with branch SHALL give IFIDFlush=1, HazardSel=1, PCWrite=1, next state BR_FLUSH.
REQ-019 RUN with load-use SHALL give HazardSel=1, PCWrite=0, IFIDWrite=0, next state LU_STALL.
REQ-020 LU_STALL and BR_FLUSH SHALL last exactly one cycle, mask load-use detection, otherwise apply RUN rules for MEM_Busy and branch, then return to RUN.
REQ-021 MEM_WAIT SHALL hold REQ-017 outputs while MEM_Busy=1; in the cycle MEM_Busy=0 it SHALL behave exactly as RUN.
REQ-022 SHALL count consecutive MEM_WAIT cycles in an 8-bit counter that saturates at 255 and clears on leaving MEM_WAIT.
REQ-023 SHALL set Timeout when the wait counter reaches 255; Timeout holds until reset.

Reset
REQ-024 reset SHALL force state RUN, wait counter 0, Timeout 0 at the next edge.
REQ-025 While reset=1, outputs SHALL be HazardSel=1, PCWrite=0, IFIDWrite=0, IFIDFlush=1, PipeHold=0, regardless of state.
REQ-026 reset asserted mid-MEM_WAIT or mid-stall SHALL abandon the operation; the first post-reset cycle is RUN.

Configuration
REQ-027 Macro HAZARD_PERF_CNT_EN SHALL add outputs StallCount and FlushCount, 32 bits each, wrapping. StallCount increments per cycle with PCWrite=0 (reset excluded). FlushCount increments per cycle with IFIDFlush=1 (reset excluded). Both are 0 on reset.
REQ-028 Without HAZARD_PERF_CNT_EN these ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Package hazard_pkg SHALL hold the state enum, NO_LOAD = 3'b101 and WAIT_LIMIT = 8'd255.
REQ-030 Counters SHALL live in sub-module hazard_perf_cnt, instantiated only under HAZARD_PERF_CNT_EN; detection and FSM stay inline.

Verification
REQ-031 Load-use: IDEX_MemRead=3'b010, IDEX_rd=5, IFID_rs2=5 -> one cycle HazardSel=1, PCWrite=0, IFIDWrite=0, then defaults.
REQ-032 x0 case: same as REQ-031 with IDEX_rd=0 -> no stall; non-load case: IDEX_MemRead=3'b101 -> no stall.
REQ-033 Simultaneous: branch plus load-use in the same cycle -> IFIDFlush=1, HazardSel=1, PCWrite=1; next cycle no stall.
REQ-034 Memory wait: MEM_Busy high for 3 cycles -> PipeHold=1 for 3 cycles, defaults on the 4th; MEM_Busy high for 300 cycles -> Timeout=1 from cycle 256 until reset.
REQ-035 Reset during MEM_WAIT: REQ-025 values while reset=1, then RUN defaults with Timeout=0. Under HAZARD_PERF_CNT_EN, 2 load-use stalls plus 1 branch -> StallCount=2, FlushCount=1.
